imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, pipelined immediate-extension stage for the decode path. Takes an `IMM_WIDTH`-bit instruction immediate, a 2-bit extension mode and an opaque tag, and produces a `DATA_WIDTH`-bit operand one cycle later. Four modes are supported: zero, sign, upper-half and branch-offset. It sits between decode and the execute operand mux with valid/ready handshakes on both sides. A 2-entry skid buffer keeps `in_ready` registered, and a synchronous flush drops in-flight entries on branch redirect.

## Interface
- `IMM_WIDTH`, 16, immediate width; must be ≥ 2.
- `DATA_WIDTH`, 32, output width; must be ≥ `IMM_WIDTH` + 2.
- `TAG_WIDTH`, 5, sideband (e.g. destination register); passed through unchanged.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: synchronous; discards all held entries.
- `in_valid` in 1: input entry present.
- `in_ready` out 1: stage can accept; registered.
- `in_imm` in `IMM_WIDTH`: raw immediate.
- `in_mode` in 2: extension mode.
- `in_tag` in `TAG_WIDTH`: sideband.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts.
- `out_data` out `DATA_WIDTH`: extended value.
- `out_tag` out `TAG_WIDTH`: sideband of the result.

## Operation
- Mode encoding (W = `DATA_WIDTH`, I = `IMM_WIDTH`):
  - 0 ZERO: `{(W-I)'0, imm}`.
  - 1 SIGN: `{(W-I){imm[I-1]}, imm}`.
  - 2 UPPER: `imm << (W-I)`, low bits 0. For 16/32 this is `{imm, 16'b0}`.
  - 3 BRANCH: sign-extend, then shift left 2. The top 2 bits of the sign extension are discarded, so the result wraps silently within W bits.
- Extension is computed combinationally at input. Registered values are always final results.
- Storage is two entries: `out_reg`, which drives the outputs, and `skid_reg`. Each entry holds data, tag and a valid bit.
- Accept condition: `in_valid && in_ready`. Out-transfer condition: `out_valid && out_ready`.
- `in_ready` = !`skid_reg.valid`, taken from the registered state.
- Per-cycle priority:
  1. `flush`: both valid bits cleared. Any accept or transfer in that cycle is ignored for state. A transfer may still be observed by the consumer.
  2. Skid valid and out-transfer: `out_reg` ← `skid_reg`, and skid is cleared. Accept is impossible here because `in_ready` = 0.
  3. Accept and (!`out_valid` or `out_ready`): `out_reg` ← new result.
  4. Accept and `out_valid` and !`out_ready`: `skid_reg` ← new result.
  5. Out-transfer with no accept: `out_reg.valid` cleared.
- Ordering is strict FIFO. No entry is dropped or duplicated except by `flush`.
- Out of reset: `out_valid`=0, `out_data`=0, `out_tag`=0, `in_ready`=1, skid empty.
- Reset mid-operation: all entries are lost immediately, asynchronously.
- `out_data`/`out_tag` hold their values while `out_valid`=0. Data registers are not cleared by flush.

## Timing
- Latency: 1 cycle. A result accepted at edge N is visible with `out_valid`=1 after edge N.
- Throughput: 1 result/cycle while `out_ready`=1.
- No combinational path from `out_ready` or `in_valid` to `in_ready`.
- After a stall begins (`out_ready`=0 with `out_reg` full), one more input is absorbed into skid. `in_ready` falls the following cycle.
- After `flush` at edge N: `out_valid`=0 and `in_ready`=1 from edge N onward.
- Simultaneous flush + `in_valid`: the input is dropped. Upstream must re-present it.

## Structure
- Package `imm_ext_pkg`:
  - mode constants `EXT_ZERO`=2'd0, `EXT_SIGN`=2'd1, `EXT_UPPER`=2'd2, `EXT_BRANCH`=2'd3;
  - mode type `ext_mode_t`.
- Sub-module `imm_ext_core`: purely combinational (imm, mode) → data, parametrised by `IMM_WIDTH`/`DATA_WIDTH`. It is instantiated once, ahead of the registers.
- Top: two-entry skid register file plus handshake control.
- Parameter check: an elaboration-time error if `DATA_WIDTH` < `IMM_WIDTH`+2.

## Test plan
- Modes, default params, `out_ready`=1, imm `16'h8001`:
  - ZERO → `32'h0000_8001`;
  - SIGN → `32'hFFFF_8001`;
  - UPPER → `32'h8001_0000`;
  - BRANCH → `32'hFFFE_0004`;
  - each appears one cycle after accept, tags 1..4 preserved.
- Backpressure: stream tags 0..7 back-to-back, `out_ready` low for cycles 2–5.
  - Required: `in_ready` drops after the second held entry.
  - All 8 emerge in order, no loss or duplication.
  - `in_ready` never depends combinationally on `out_ready`.
- Flush with both entries full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; neither held entry nor the presented one ever appears.
- Async reset asserted mid-stream with skid full → outputs immediately at reset values; after release, first accepted entry emerges one cycle later.
- Alternate params `IMM_WIDTH`=12, `DATA_WIDTH`=64, imm `12'hFFF`:
  - SIGN → all ones;
  - UPPER → `64'hFFF0_0000_0000_0000`;
  - BRANCH → `64'hFFFF_FFFF_FFFF_FFFC`.
- Random traffic: random valid/ready/flush with a scoreboard reference model → zero mismatches over 10k cycles.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the decode-path immediate-extension stage:
// extension mode encoding used by the core and the pipeline top.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'd0,
        EXT_SIGN   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: widens an IMM_WIDTH immediate to
// DATA_WIDTH according to the selected extension mode.
module imm_ext_core #(
    parameter int IMM_WIDTH  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] data
);
    import imm_ext_pkg::*;

    localparam int PAD = DATA_WIDTH - IMM_WIDTH;

    logic [DATA_WIDTH-1:0] sext;

    assign sext = {{PAD{imm[IMM_WIDTH-1]}}, imm};

    always_comb begin
        data = '0;
        case (ext_mode_t'(mode))
            EXT_ZERO:   data = {{PAD{1'b0}}, imm};
            EXT_SIGN:   data = sext;
            EXT_UPPER:  data = {imm, {PAD{1'b0}}};
            // Branch offsets are word-scaled; the top two sign bits fall off.
            EXT_BRANCH: data = {sext[DATA_WIDTH-3:0], 2'b00};
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// One-cycle immediate-extension stage with valid/ready on both sides and a
// two-entry (output + skid) register file so in_ready comes straight from a flop.
module imm_ext_pipe #(
    parameter int IMM_WIDTH  = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IMM_WIDTH-1:0]  in_imm,
    input  logic [1:0]            in_mode,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag
);
    import imm_ext_pkg::*;

    if (IMM_WIDTH < 2) begin : g_bad_imm_width
        $error("imm_ext_pipe: IMM_WIDTH must be at least 2");
    end
    if (DATA_WIDTH < IMM_WIDTH + 2) begin : g_bad_data_width
        $error("imm_ext_pipe: DATA_WIDTH must be at least IMM_WIDTH + 2");
    end

    logic [DATA_WIDTH-1:0] ext_data;

    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_reg,  out_data_next;
    logic [TAG_WIDTH-1:0]  out_tag_reg,   out_tag_next;
    logic                  skid_valid_reg, skid_valid_next;
    logic [DATA_WIDTH-1:0] skid_data_reg,  skid_data_next;
    logic [TAG_WIDTH-1:0]  skid_tag_reg,   skid_tag_next;

    logic accept;
    logic xfer;

    imm_ext_core #(
        .IMM_WIDTH  (IMM_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data)
    );

    assign in_ready  = !skid_valid_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_tag   = out_tag_reg;

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid_reg && out_ready;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_tag_next    = out_tag_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_tag_next   = skid_tag_reg;

        // Flush only drops valid bits; data stays so the outputs hold steady.
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg && xfer) begin
            out_data_next   = skid_data_reg;
            out_tag_next    = skid_tag_reg;
            skid_valid_next = 1'b0;
        end else if (accept && (!out_valid_reg || out_ready)) begin
            out_valid_next = 1'b1;
            out_data_next  = ext_data;
            out_tag_next   = in_tag;
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = ext_data;
            skid_tag_next   = in_tag;
        end else if (xfer) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_tag_reg    <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_tag_reg   <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_tag_reg    <= out_tag_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_tag_reg   <= skid_tag_next;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a queue-based reference of the two-deep stage checked
// every cycle, plus directed vectors with literal expected values.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    logic        w_flush = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_out_ready = 1'b1;
    logic [11:0] w_imm = '0;
    logic [1:0]  w_mode = '0;
    logic [4:0]  w_tag = '0;
    logic        w_in_ready, w_out_valid;
    logic [63:0] w_out_data;
    logic [4:0]  w_out_tag;

    always #5 clk = ~clk;

    imm_ext_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    imm_ext_pipe #(.IMM_WIDTH(12), .DATA_WIDTH(64), .TAG_WIDTH(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(w_flush),
        .in_valid(w_valid), .in_ready(w_in_ready),
        .in_imm(w_imm), .in_mode(w_mode), .in_tag(w_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_tag(w_out_tag)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Extension by arithmetic on the signed/unsigned value of the immediate.
    function automatic logic [63:0] ext_model(input logic [63:0] imm, input int iw,
                                              input int w, input int mode);
        longint u, s, r;
        u = longint'(imm);
        s = imm[iw-1] ? (u - (longint'(1) <<< iw)) : u;
        case (mode)
            0:       r = u;
            1:       r = s;
            2:       r = u * (longint'(1) <<< (w - iw));
            default: r = s * 4;
        endcase
        if (w < 64) r = r & ((longint'(1) <<< w) - 1);
        return 64'(r);
    endfunction

    // Reference: the stage behaves as a FIFO of depth two.
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_data = '0;
    logic [4:0]  m_tag = '0;
    bit          m_acc, m_pop;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_data = '0;
            m_tag  = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_pop = (q.size() > 0) && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back('{d: 32'(ext_model(64'(in_imm), 16, 32, int'(in_mode))), t: in_tag});
            if (q.size() > 0) begin
                m_data = q[0].d;
                m_tag  = q[0].t;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("model_in_ready", in_ready, q.size() < 2);
            check("model_out_valid", out_valid, q.size() > 0);
            check("model_out_data", out_data, m_data);
            check("model_out_tag", out_tag, m_tag);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] lit32 [4];
    logic [63:0] lit64 [4];
    int          got[$];
    int          k, c;
    bit          rdy_s;

    initial begin
        lit32 = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004};
        lit64 = '{64'h0000_0000_0000_0FFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFF0_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFC};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);

        // Four modes on 16'h8001, one cycle latency each.
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1;
            in_imm   = 16'h8001;
            in_mode  = m[1:0];
            in_tag   = 5'(m + 1);
            @(negedge clk);
            check("mode_valid", out_valid, 1);
            check("mode_data", out_data, lit32[m]);
            check("mode_tag", out_tag, 64'(m + 1));
            check("model_pin32", ext_model(64'h8001, 16, 32, m), lit32[m]);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: tags 0..7 streamed, consumer stalls for cycles 2..5.
        k = 0;
        c = 0;
        while (got.size() < 8 && c < 60) begin
            out_ready = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
            in_valid  = (k < 8);
            in_imm    = 16'(k * 37 + 16'h7FF0);
            in_mode   = EXT_SIGN;
            in_tag    = 5'(k);
            if (c == 2) check("bp_ready_c2", in_ready, 1);
            if (c == 3) check("bp_ready_c3", in_ready, 0);
            if (c == 4) begin
                out_ready = 1'b1;
                #1 check("bp_ready_no_comb", in_ready, 0);
                out_ready = 1'b0;
            end
            if (out_valid && out_ready) got.push_back(int'(out_tag));
            rdy_s = in_ready;
            @(posedge clk);
            if (in_valid && rdy_s) k++;
            @(negedge clk);
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(got.size()), 8);
        for (int i = 0; i < got.size(); i++) check("bp_order", 64'(got[i]), 64'(i));
        @(negedge clk);

        // Flush with both entries held and a new input presented.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_mode   = EXT_ZERO;
        in_imm    = 16'h1234;
        in_tag    = 5'd20;
        @(negedge clk);
        in_tag = 5'd21;
        @(negedge clk);
        check("fl_pre_ready", in_ready, 0);
        in_tag = 5'd22;
        flush  = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("fl_gone", out_valid, 0);
        end

        // Asynchronous reset with the skid entry occupied.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_tag    = 5'd9;
        @(negedge clk);
        in_tag = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        check("rs_pre_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rs_out_valid", out_valid, 0);
        check("rs_in_ready", in_ready, 1);
        check("rs_out_data", out_data, 0);
        check("rs_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_imm    = 16'h0005;
        in_mode   = EXT_SIGN;
        in_tag    = 5'd11;
        @(negedge clk);
        in_valid = 1'b0;
        check("rs_first_valid", out_valid, 1);
        check("rs_first_data", out_data, 64'h5);
        check("rs_first_tag", out_tag, 11);

        // Alternate parameters: 12-bit immediate into 64 bits.
        for (int m = 1; m < 4; m++) begin
            w_valid = 1'b1;
            w_imm   = 12'hFFF;
            w_mode  = m[1:0];
            w_tag   = 5'(m);
            @(negedge clk);
            check("w64_valid", w_out_valid, 1);
            check("w64_data", w_out_data, lit64[m]);
            check("w64_tag", w_out_tag, 64'(m));
            check("model_pin64", ext_model(64'hFFF, 12, 64, m), lit64[m]);
        end
        w_valid = 1'b0;

        // Random traffic against the reference.
        repeat (10000) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
